pll_lock_sequencer: RTL and testbench

//   Owns the reset and lock sequencing of the system PLL (10 MHz refclk -> 20 MHz outclk_0).

---
 rtl/pll_lock_sequencer.sv | 125 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with timeout and retries,
// qualifies lock as stable and holds the downstream system reset until then. Runs on refclk.
module pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 10000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned LOSS_CNT_W       = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  restart_req,
    output logic                  pll_rst,
    output logic                  sys_rst,
    output logic                  clk_ready,
    output logic                  fail,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int unsigned MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned TMR_MAX = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int unsigned RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0]   PULSE_LAST   = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]   STABLE_LAST  = TMR_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [TMR_W-1:0]     timer;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [RETRY_W-1:0]   retry_nx;
    logic                 sync_meta;
    logic                 locked_s;
    logic                 timer_clr;
    logic                 loss_inc;

    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        if (restart_req) begin
            state_nx = RESET_PLL;
            retry_nx = '0;
        end else begin
            case (state)
                RESET_PLL: begin
                    if (timer == PULSE_LAST)
                        state_nx = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nx = STABLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        retry_nx = retry_cnt + RETRY_W'(1);
                        state_nx = (retry_nx == RETRY_LIMIT) ? FAIL : RESET_PLL;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_nx = WAIT_LOCK;
                    end else if (timer == STABLE_LAST) begin
                        state_nx = RUN;
                        retry_nx = '0;
                    end
                end
                RUN: begin
                    if (!locked_s)
                        state_nx = RESET_PLL;
                end
                FAIL: begin
                    state_nx = FAIL;
                end
                default: begin
                    state_nx = RESET_PLL;
                end
            endcase
        end
    end

    // restart_req in RESET_PLL is a self-loop that must still restart the pulse timer
    assign timer_clr = restart_req || (state_nx != state);
    assign loss_inc  = (state == RUN) && !locked_s && (lock_loss_cnt != '1);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= RESET_PLL;
            retry_cnt     <= '0;
            timer         <= '0;
            sync_meta     <= 1'b0;
            locked_s      <= 1'b0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            clk_ready     <= 1'b0;
            fail          <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
            state     <= state_nx;
            retry_cnt <= retry_nx;
            if (timer_clr)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + TMR_W'(1);
            if (loss_inc)
                lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
            pll_rst   <= (state_nx == RESET_PLL) || (state_nx == FAIL);
            sys_rst   <= (state_nx != RUN);
            clk_ready <= (state_nx == RUN);
            fail      <= (state_nx == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed lock scenarios plus randomized
// lock/restart/reset traffic, compared every cycle against a countdown-based phase model.
module tb_pll_lock_sequencer;

    localparam int RP = 4;
    localparam int TO = 50;
    localparam int SC = 8;
    localparam int MR = 2;
    localparam int LW = 8;
    localparam int LOSS_MAX = (1 << LW) - 1;

    logic          refclk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          restart_req;
    logic          pll_rst;
    logic          sys_rst;
    logic          clk_ready;
    logic          fail;
    logic [LW-1:0] lock_loss_cnt;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_PULSE_CYC    (RP),
        .LOCK_TIMEOUT_CYC (TO),
        .LOCK_STABLE_CYC  (SC),
        .MAX_RETRY        (MR),
        .LOSS_CNT_W       (LW)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .restart_req   (restart_req),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .clk_ready     (clk_ready),
        .fail          (fail),
        .lock_loss_cnt (lock_loss_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phases with cycles-remaining countdowns, lock seen two edges late
    typedef enum {PH_PULSE, PH_WAIT, PH_QUAL, PH_RUN, PH_DEAD} phase_t;
    phase_t ph;
    int     left;
    int     tries;
    int     losses;
    bit     lk_q[$];

    task automatic enter(input phase_t p);
        ph = p;
        case (p)
            PH_PULSE: left = RP;
            PH_WAIT:  left = TO;
            PH_QUAL:  left = SC;
            default:  left = 0;
        endcase
    endtask

    task automatic model_reset();
        enter(PH_PULSE);
        tries  = 0;
        losses = 0;
        lk_q   = '{1'b0, 1'b0};
    endtask

    task automatic model_step();
        bit ls;
        ls = lk_q.pop_front();
        lk_q.push_back(pll_locked);
        if (ph == PH_RUN && !ls && losses < LOSS_MAX)
            losses++;
        if (restart_req) begin
            tries = 0;
            enter(PH_PULSE);
        end else begin
            case (ph)
                PH_PULSE: begin
                    left--;
                    if (left == 0) enter(PH_WAIT);
                end
                PH_WAIT: begin
                    if (ls) enter(PH_QUAL);
                    else begin
                        left--;
                        if (left == 0) begin
                            tries++;
                            if (tries == MR) enter(PH_DEAD);
                            else enter(PH_PULSE);
                        end
                    end
                end
                PH_QUAL: begin
                    if (!ls) enter(PH_WAIT);
                    else begin
                        left--;
                        if (left == 0) begin
                            tries = 0;
                            enter(PH_RUN);
                        end
                    end
                end
                PH_RUN: if (!ls) enter(PH_PULSE);
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check("pll_rst",   pll_rst,   (ph == PH_PULSE) || (ph == PH_DEAD));
        check("sys_rst",   sys_rst,   ph != PH_RUN);
        check("clk_ready", clk_ready, ph == PH_RUN);
        check("fail",      fail,      ph == PH_DEAD);
        check("loss_cnt",  lock_loss_cnt, losses);
    endtask

    task automatic tick();
        @(posedge refclk);
        if (rst) model_reset();
        else model_step();
        @(negedge refclk);
        compare_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        check("arst_pll_rst",   pll_rst, 1);
        check("arst_sys_rst",   sys_rst, 1);
        check("arst_clk_ready", clk_ready, 0);
        check("arst_fail",      fail, 0);
        check("arst_loss_cnt",  lock_loss_cnt, 0);
        tick();
        rst = 1'b0;
    endtask

    int n;
    int hi;
    int saw_rst;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        restart_req = 1'b0;
        model_reset();
        #1;
        check("rst_pll_rst",   pll_rst, 1);
        check("rst_sys_rst",   sys_rst, 1);
        check("rst_clk_ready", clk_ready, 0);
        check("rst_fail",      fail, 0);
        check("rst_loss_cnt",  lock_loss_cnt, 0);
        repeat (3) tick();
        rst = 1'b0;

        // 1. Normal lock
        hi = pll_rst;
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += pll_rst;
        end
        pll_locked = 1'b1;
        n = 0;
        while (!clk_ready && n < 100) begin
            tick();
            n++;
            hi += pll_rst;
        end
        check("s1_ready_lat", n, 11);
        check("s1_pulse_len", hi, 4);
        check("s1_sys_rst",   sys_rst, 0);

        // 4. Loss of lock in RUN, then saturate the loss counter
        pll_locked = 1'b0;
        n = 0;
        while (clk_ready && n < 20) begin
            tick();
            n++;
        end
        check("s4_loss_lat", n, 3);
        check("s4_loss_cnt", lock_loss_cnt, 1);
        check("s4_sys_rst",  sys_rst, 1);
        hi = pll_rst;
        repeat (10) begin
            tick();
            hi += pll_rst;
        end
        check("s4_pulse_len", hi, 4);
        for (int k = 0; k < 299; k++) begin
            pll_locked = 1'b1;
            n = 0;
            while (!clk_ready && n < 200) begin
                tick();
                n++;
            end
            pll_locked = 1'b0;
            n = 0;
            while (clk_ready && n < 20) begin
                tick();
                n++;
            end
        end
        check("s4_saturate", lock_loss_cnt, 255);

        // 5b. Asynchronous reset in the middle of STABLE
        pll_locked = 1'b1;
        n = 0;
        while (ph != PH_QUAL && n < 50) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("s5b_in_stable", pll_rst, 0);
        async_reset();
        pll_locked = 1'b0;

        // 2. Timeout and retry to FAIL
        hi = pll_rst;
        n = 0;
        while (!fail && n < 300) begin
            tick();
            n++;
            if (!fail) hi += pll_rst;
        end
        check("s2_fail_lat", n, 108);
        check("s2_pulse_hi", hi, 8);
        repeat (20) tick();
        check("s2_fail_hold",  fail, 1);
        check("s2_pll_rst",    pll_rst, 1);
        check("s2_sys_rst",    sys_rst, 1);

        // 5a. restart_req from FAIL reruns with a fresh retry budget
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        check("s5_fail_clr", fail, 0);
        check("s5_pll_rst",  pll_rst, 1);
        n = 0;
        while (!fail && n < 300) begin
            tick();
            n++;
        end
        check("s5_refail", n, 108);

        // 3. Unstable lock: high 5, low 3, then high
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        n = 0;
        while (pll_rst && n < 20) begin
            tick();
            n++;
        end
        saw_rst = 0;
        n = 0;
        while (!clk_ready && n < 60) begin
            pll_locked = (n + 1 <= 5) || (n + 1 >= 9);
            tick();
            n++;
            if (pll_rst) saw_rst = 1;
        end
        check("s3_ready_lat", n, 19);
        check("s3_no_pulse",  saw_rst, 0);

        // Randomized lock traffic with occasional restart and reset
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            pll_locked = $urandom_range(0, 2) != 0;
            len = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 70);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 799) == 0) begin
                    async_reset();
                end else begin
                    restart_req = ($urandom_range(0, 149) == 0);
                    tick();
                    restart_req = 1'b0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
